// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM encoding,
// largest representable decimal value and the saturation (all-nines) pattern.
package bin2bcd_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int MAX_DIGITS = 8;

    // 10^digits - 1, the largest value that fits in the BCD output
    function automatic int unsigned max_bcd_value(input int digits);
        int unsigned v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    function automatic logic [4*MAX_DIGITS-1:0] all_nines(input int digits);
        logic [4*MAX_DIGITS-1:0] p;
        p = '0;
        for (int i = 0; i < digits; i++) begin
            p[4*i +: 4] = 4'h9;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between the measurement logic (master) and the
// binary-to-BCD converter (slave).
interface bin2bcd_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Optional build macro BIN2BCD_SAT_EN forces all nines on overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    bin2bcd_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = max_bcd_value(DIGITS);
`ifdef BIN2BCD_SAT_EN
    localparam logic [4*MAX_DIGITS-1:0] NINES_ALL = all_nines(DIGITS);
    localparam logic [BCD_W-1:0]        NINES     = NINES_ALL[BCD_W-1:0];
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic [BCD_W-1:0] acc_next;
    logic [BIN_W-1:0] sr;
    logic [BCD_W-1:0] bcd_q;
    logic             ovf_int;
    logic             ovf_q;
    logic [BCD_W-1:0] bcd_final;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (acc[4*g +: 4]),
                .digit_out (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // Shifting out the top accumulator bit is what yields bin mod 10^DIGITS
    assign acc_next = (acc_adj << 1) | BCD_W'(sr[BIN_W-1]);

`ifdef BIN2BCD_SAT_EN
    assign bcd_final = ovf_int ? NINES : acc_next;
`else
    assign bcd_final = acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            sr      <= '0;
            bcd_q   <= '0;
            ovf_int <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr      <= bus.bin;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf_int <= (32'(bus.bin) > MAX_VAL);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    sr  <= sr << 1;
                    cnt <= cnt + 1'b1;
                    // Publish on the final shift so results appear with done
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        bcd_q <= bcd_final;
                        ovf_q <= ovf_int;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq; expected BCD values are hand-computed.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bin2bcd_if #(.BIN_W(14), .DIGITS(4)) bif ();

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; returns in the first SHIFT cycle (T+1)
    task automatic apply_stimulus(input logic [13:0] value);
        bif.bin   = value;
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!bif.done && n < 60) begin
            step();
            n++;
        end
    endtask

    int n;
    int done_at;
    int extra;
    logic [15:0] exp_ovf_a;
    logic [15:0] exp_ovf_b;

    initial begin
`ifdef BIN2BCD_SAT_EN
        exp_ovf_a = 16'h9999;
        exp_ovf_b = 16'h9999;
`else
        exp_ovf_a = 16'h0000;
        exp_ovf_b = 16'h6383;
`endif
        rst_n     = 1'b0;
        bif.start = 1'b0;
        bif.bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_bcd", 32'(bif.bcd), 32'h0);
        check_output("reset_busy", 32'(bif.busy), 32'h0);
        check_output("reset_done", 32'(bif.done), 32'h0);
        check_output("reset_ovf", 32'(bif.overflow), 32'h0);
        rst_n = 1'b1;
        step();

        // Nominal 1234 with cycle-exact busy/done profile
        apply_stimulus(14'd1234);
        for (int k = 1; k <= 15; k++) begin
            check_output($sformatf("nom_busy_k%0d", k), 32'(bif.busy), 32'h1);
            check_output($sformatf("nom_done_k%0d", k), 32'(bif.done), (k == 15) ? 32'h1 : 32'h0);
            if (k < 15) step();
        end
        check_output("nom_bcd", 32'(bif.bcd), 32'h1234);
        check_output("nom_ovf", 32'(bif.overflow), 32'h0);
        step();
        check_output("nom_idle_busy", 32'(bif.busy), 32'h0);
        check_output("nom_idle_done", 32'(bif.done), 32'h0);
        check_output("nom_hold_bcd", 32'(bif.bcd), 32'h1234);

        // Zero then 9999 back-to-back with start held high
        bif.bin   = 14'd0;
        bif.start = 1'b1;
        step();
        bif.bin = 14'd9999;
        wait_done(n);
        check_output("zero_latency", 32'(n), 32'd15);
        check_output("zero_bcd", 32'(bif.bcd), 32'h0000);
        step();
        check_output("b2b_idle_busy", 32'(bif.busy), 32'h0);
        step();
        check_output("b2b_restart_busy", 32'(bif.busy), 32'h1);
        bif.start = 1'b0;
        wait_done(n);
        check_output("b2b_done_gap", 32'(n + 1), 32'd16);
        check_output("max_bcd", 32'(bif.bcd), 32'h9999);
        check_output("max_ovf", 32'(bif.overflow), 32'h0);
        step();

        // Overflow inputs
        apply_stimulus(14'd10000);
        wait_done(n);
        check_output("ovf10000_latency", 32'(n), 32'd15);
        check_output("ovf10000_flag", 32'(bif.overflow), 32'h1);
        check_output("ovf10000_bcd", 32'(bif.bcd), 32'(exp_ovf_a));
        step();
        apply_stimulus(14'd16383);
        wait_done(n);
        check_output("ovf16383_flag", 32'(bif.overflow), 32'h1);
        check_output("ovf16383_bcd", 32'(bif.bcd), 32'(exp_ovf_b));
        step();

        // 42 with bin changed mid-flight and a start pulse while busy
        apply_stimulus(14'd42);
        done_at = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) bif.bin = 14'd5555;
            if (k == 5) begin
                bif.bin   = 14'd777;
                bif.start = 1'b1;
            end else begin
                bif.start = 1'b0;
            end
            if (bif.done && done_at == 0) done_at = k;
            if (k < 15) step();
        end
        check_output("busy_start_done_at", 32'(done_at), 32'd15);
        check_output("busy_start_bcd", 32'(bif.bcd), 32'h0042);
        check_output("busy_start_ovf", 32'(bif.overflow), 32'h0);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bif.done) extra++;
        end
        check_output("busy_start_no_second", 32'(extra), 32'd0);
        check_output("busy_start_idle", 32'(bif.busy), 32'h0);

        // Reset in the middle of a 4321 conversion
        apply_stimulus(14'd4321);
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", 32'(bif.busy), 32'h0);
        check_output("midrst_done", 32'(bif.done), 32'h0);
        check_output("midrst_bcd", 32'(bif.bcd), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bif.done) extra++;
        end
        check_output("midrst_no_done", 32'(extra), 32'd0);
        check_output("midrst_idle_busy", 32'(bif.busy), 32'h0);
        apply_stimulus(14'd4321);
        wait_done(n);
        check_output("rerun_latency", 32'(n), 32'd15);
        check_output("rerun_bcd", 32'(bif.bcd), 32'h4321);
        check_output("rerun_ovf", 32'(bif.overflow), 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble).
- Sits directly upstream of the 4-digit 7-segment display multiplexer in the delay-measurement design.
- Converts the binary measurement count into packed BCD nibbles, so the display shows decimal instead of hex.
- The packed result drives the display's 16-bit number input.

Parameters:
- BIN_W, 14, width of the binary input; 14 covers 0..16383.
- DIGITS, 4, number of BCD output digits; output width is 4*DIGITS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a conversion; sampled only when busy=0.
- bin  in  BIN_W  binary value; captured in the cycle start is accepted.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; bcd/overflow are updated in this same cycle.
- bcd  out  4*DIGITS  packed BCD, digit 0 in [3:0]; holds its value between conversions.
- overflow  out  1  last converted bin exceeded 10^DIGITS-1; held with bcd.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: bcd=0, overflow=0, busy=0, done=0, state=IDLE, shift counter=0.
  - rst_n asserted mid-conversion aborts immediately; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - When start=1: capture bin into a shift register, clear the internal BCD accumulator, set counter=0, go to SHIFT.
  - Compute the overflow flag from bin > 10^DIGITS-1 and hold it internally.
- SHIFT, one iteration per cycle:
  - Every accumulator digit >= 5 gets +3.
  - Then shift {accumulator, binary register} left by 1.
  - The top accumulator bit is discarded, so the result is bin mod 10^DIGITS.
  - counter increments; after BIN_W iterations go to DONE.
- DONE, one cycle:
  - done=1.
  - bcd and overflow outputs update from the accumulator and the internal flag.
  - Next state IDLE.
- busy timing: busy=1 in SHIFT and DONE.
- start handling:
  - start while busy=1 is ignored, not queued.
  - start held high continuously restarts a conversion in the first IDLE cycle after DONE.
- Latency: start accepted in cycle T → done=1 and new bcd visible in cycle T+BIN_W+1. Throughput is one conversion per BIN_W+2 cycles.
- bin changes after capture have no effect on the running conversion.
- Width rules:
  - Counter width is clog2(BIN_W+1).
  - The add-3 is a 4-bit add; a digit never exceeds 9 before correction.
- Outputs are registered; no combinational path from start/bin to any output.

Optional Feature:
- Macro: BIN2BCD_SAT_EN.
- Defined: when overflow=1, bcd is forced to all nines (0x9999 for DIGITS=4) in the DONE cycle.
- Not defined: bcd carries bin mod 10^DIGITS.
- overflow behaves identically in both builds.
- Cycle timing is identical in both builds.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Function/constant for 10^DIGITS-1.
  - The all-nines pattern.
- One natural sub-module: bcd_digit_adj.
  - Combinational 4-bit "if >=5 add 3" corrector.
  - Instantiated DIGITS times via generate.

Test Plan:
- Nominal value: reset, then bin=1234 with start pulse at cycle T → busy high T+1..T+15, done=1 at T+15, bcd=0x1234, overflow=0.
- Zero and maximum: bin=0 → bcd=0x0000. Then bin=9999 → bcd=0x9999, overflow=0. Back-to-back with start held high, second done exactly 16 cycles after the first.
- Overflow: bin=10000 and bin=16383 → overflow=1.
  - Build with BIN2BCD_SAT_EN: bcd=0x9999 both times.
  - Build without it: bcd=0x0000 and 0x6383.
- Start while busy: start=1 with bin=42, then bin=777 with start pulsed at T+5 → single done at T+15, bcd=0x0042, no second conversion.
- Input held stable in flight: bin changed to 5555 at T+3 during the 42 conversion → result still 0x0042.
- Reset mid-operation: assert rst_n=0 at T+7 of a 4321 conversion, release 2 cycles later → bcd=0, busy=0, no done pulse. A new start with 4321 yields 0x4321 after 15 cycles.
